uart_cmd_frame: RTL and testbench
=================================

# uart_cmd_frame

UART command-frame receiver that produces the 240-bit effect-parameter word consumed by the audio effect chain: echo, reverb, chorus, compressor, phaser, distortion, EQ, interpolation/decimation and the remote filter. It sits directly upstream of the parameter bus. It receives 8N1 serial bytes, validates a headered and checksummed frame, and updates the parameter word atomically. A one-cycle strobe marks each accepted update, which the LFO-based effects use as their write strobe. Corrupted, truncated or misframed frames never reach the effect chain.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud); must be ≥ 8.
- PAYLOAD_BYTES, default 30: payload bytes per frame; the command word is 8×PAYLOAD_BYTES bits.
- TIMEOUT_CYCLES, default 100000: maximum idle time between bytes inside a frame.
- clk  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input, idles high.
- cmd_word  out  8×PAYLOAD_BYTES  current parameter word; reset value 0, so all effect enables are off.
- cmd_valid  out  1  one-cycle pulse when cmd_word updates; reset value 0.
- frame_err  out  1  one-cycle pulse on any discarded frame or byte; reset value 0.
- busy  out  1  high while a frame is in progress (any parser state other than HDR0); reset value 0.

## Operation
- **Input synchronizer:** uart_rx passes through a 2-flop synchronizer. Both flops reset to 1.
- **Bit receiver states:** IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - START waits CLKS_PER_BIT/2 (integer division) cycles, then samples. If the line is high, this is a glitch: return to IDLE with no error. If low, go to DATA.
  - DATA samples 8 bits LSB first, each CLKS_PER_BIT cycles apart.
  - STOP samples once after a further CLKS_PER_BIT cycles.
    - Stop bit = 1: the byte strobe fires for one cycle.
    - Stop bit = 0: framing error. The byte is dropped, frame_err pulses, and the parser is forced to HDR0.
    - In both cases the receiver returns to IDLE, then waits for the line to be high before re-arming.
- **Frame format:** 0xAA, 0x55, PAYLOAD_BYTES payload bytes, checksum byte.
  - The checksum is the 8-bit sum, mod 256, of the payload bytes only.
  - Payload byte 0 maps to cmd_word[MSB:MSB-7]; the last payload byte maps to cmd_word[7:0].
- **Parser states:** HDR0, HDR1, PAYLOAD, CSUM.
  - HDR0: byte 0xAA → HDR1; any other byte is ignored.
  - HDR1: byte 0x55 → PAYLOAD with the byte index cleared to 0; byte 0xAA → stay in HDR1; any other byte → HDR0. None of these raise an error.
  - PAYLOAD: each byte is written into a shadow register at the current index and added into the running sum. After byte index PAYLOAD_BYTES-1, go to CSUM.
  - CSUM, checksum matches: copy the shadow register into cmd_word in a single edge, pulse cmd_valid, go to HDR0.
  - CSUM, mismatch: pulse frame_err, leave cmd_word unchanged, go to HDR0.
- **Inter-byte timeout:** a counter clears on every byte strobe and on entering HDR1. It counts only while the parser is outside HDR0. On reaching TIMEOUT_CYCLES it pulses frame_err and forces HDR0.
- **Shadow register:** never visible on cmd_word until a valid checksum; a partial frame has no effect on the outputs.
- **Reset:** asserting reset at any point (including mid-byte or mid-frame) immediately clears the receiver, parser, shadow register, sum, counters and all outputs to their reset values.

## Timing
- **Synchronizer delay:** the synchronized line lags uart_rx by 2 cycles.
- **Stop-bit sample point:** CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after the synchronized falling edge. The byte strobe is asserted in that cycle.
- **Update latency:** cmd_word and cmd_valid update on the clock edge after the checksum byte's strobe. Both change in the same cycle. cmd_valid is high for exactly 1 cycle.
- **Error pulse timing:**
  - Checksum mismatch: frame_err at the same position cmd_valid would have had.
  - Framing error: frame_err in the cycle after the stop-bit sample.
  - Timeout: frame_err in the cycle after the counter reaches TIMEOUT_CYCLES.
- **Mutual exclusion:** cmd_valid and frame_err are never high in the same cycle.
- **Back-to-back frames:** the next start bit may begin immediately after a stop bit. No dead time is required between frames.

## Test plan
- **Reset values:** assert reset for 5 cycles → cmd_word=0, cmd_valid=0, frame_err=0, busy=0. Release with uart_rx held high for 10000 cycles → no change.
- **Good frame:** send AA 55, then payload 01..1E, then checksum 0xD1 → one cmd_valid pulse; cmd_word[239:232]=0x01 and cmd_word[7:0]=0x1E; busy drops with the pulse.
- **Bad checksum:** the same frame with checksum 0xD0 → frame_err pulses once, cmd_valid stays 0, cmd_word keeps its previous value.
- **Header resync:** send 12 AA AA 55, then a valid frame → accepted, with cmd_valid asserted once.
- **Timeout:** send AA 55 and 10 payload bytes, then idle for TIMEOUT_CYCLES+10 → frame_err pulses once, busy=0. A following valid frame is accepted.
- **Mid-frame disturbances:**
  - Force a 0 stop bit on payload byte 5 → frame_err, and the frame is discarded.
  - Assert reset during payload byte 20 → all outputs return to 0. A subsequent valid frame is accepted.

Source files
------------

// File: rtl/uart_cmd_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_frame
// Purpose  : 8N1 UART receiver with a headered, checksummed command-frame
//            parser. A frame that passes its checksum is copied into the
//            parameter word in a single edge.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_frame #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int PAYLOAD_BYTES  = 30,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx,
    output logic [8*PAYLOAD_BYTES-1:0] cmd_word,
    output logic                       cmd_valid,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int c_W      = 8 * PAYLOAD_BYTES;
    localparam int c_BIT_CW = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(PAYLOAD_BYTES + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_BIT_CW-1:0] c_HALF_M1  = c_BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BIT_CW-1:0] c_FULL_M1  = c_BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_CW-1:0] c_BIT_ONE  = c_BIT_CW'(1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX  = c_TMO_W'(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [7:0]          c_HDR_A    = 8'hAA;
    localparam logic [7:0]          c_HDR_B    = 8'h55;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HDR0    = 2'd0,
        P_HDR1    = 2'd1,
        P_PAYLOAD = 2'd2,
        P_CSUM    = 2'd3
    } p_state_t;

    // receiver
    logic                r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t           r_rx_state, w_rx_next;
    logic [c_BIT_CW-1:0] r_bit_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                w_rx_fall, w_bit_done, w_byte_stb, w_stop_err;

    // parser
    p_state_t            r_p_state, w_p_next;
    logic [c_IDX_W-1:0]  r_idx;
    logic [7:0]          r_sum;
    logic [c_W-1:0]      r_shadow;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                w_timeout, w_commit, w_csum_bad;

    assign w_rx_fall  = r_rx_prev & ~r_rx_sync;
    assign w_bit_done = (r_bit_cnt == c_FULL_M1);
    assign w_timeout  = (r_p_state != P_HDR0) && (r_tmo_cnt == c_TMO_MAX);
    assign busy       = (r_p_state != P_HDR0);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver state, bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_bit_done) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
            end
            if (r_rx_state == RX_START) begin
                r_bit_idx <= 3'd0;
            end
            if (r_rx_state == RX_DATA && w_bit_done) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // Receiver next state; the byte strobe and stop-bit error both fire in the stop-sample cycle.
    always_comb begin
        w_rx_next  = r_rx_state;
        w_byte_stb = 1'b0;
        w_stop_err = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (r_bit_cnt == c_HALF_M1) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_done && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_bit_done) begin
                    w_rx_next = RX_IDLE;
                    if (r_rx_sync) begin
                        w_byte_stb = 1'b1;
                    end else begin
                        w_stop_err = 1'b1;
                    end
                end
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Parser next state; line errors and timeout take priority over any byte.
    always_comb begin
        w_p_next   = r_p_state;
        w_commit   = 1'b0;
        w_csum_bad = 1'b0;
        if (w_stop_err || w_timeout) begin
            w_p_next = P_HDR0;
        end else if (w_byte_stb) begin
            case (r_p_state)
                P_HDR0: if (r_shift == c_HDR_A) w_p_next = P_HDR1;
                P_HDR1: begin
                    if (r_shift == c_HDR_B) begin
                        w_p_next = P_PAYLOAD;
                    end else if (r_shift != c_HDR_A) begin
                        w_p_next = P_HDR0;
                    end
                end
                P_PAYLOAD: if (r_idx == c_IDX_LAST) w_p_next = P_CSUM;
                P_CSUM: begin
                    w_p_next = P_HDR0;
                    if (r_shift == r_sum) begin
                        w_commit = 1'b1;
                    end else begin
                        w_csum_bad = 1'b1;
                    end
                end
                default: w_p_next = P_HDR0;
            endcase
        end
    end

    // Parser state, shadow capture, running sum, timeout counter and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_state <= P_HDR0;
            r_idx     <= '0;
            r_sum     <= 8'd0;
            r_shadow  <= '0;
            r_tmo_cnt <= '0;
            cmd_word  <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_p_state <= w_p_next;
            cmd_valid <= w_commit;
            frame_err <= w_stop_err | w_timeout | w_csum_bad;
            if (w_commit) begin
                cmd_word <= r_shadow;
            end
            if (w_byte_stb || r_p_state == P_HDR0) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end
            if (w_byte_stb && r_p_state == P_HDR1) begin
                r_idx <= '0;
                r_sum <= 8'd0;
            end
            if (w_byte_stb && r_p_state == P_PAYLOAD) begin
                r_sum <= r_sum + r_shift;
                r_idx <= r_idx + c_IDX_ONE;
                // Payload byte 0 lands in the most significant byte.
                for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                    if (r_idx == c_IDX_W'(i)) begin
                        r_shadow[c_W-1-8*i -: 8] <= r_shift;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_frame
// Purpose  : Self-checking bench for uart_cmd_frame: frame-level reference
//            model with exact pulse-timing expectations and a per-cycle
//            output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_frame;

    localparam int C = 10;
    localparam int P = 30;
    localparam int T = 1000;
    localparam int W = 8 * P;
    // cycles from the synchronized falling edge to the stop-bit sample
    localparam int N = C / 2 + 9 * C;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         uart_rx = 1'b1;
    logic [W-1:0] cmd_word;
    logic         cmd_valid;
    logic         frame_err;
    logic         busy;

    uart_cmd_frame #(
        .CLKS_PER_BIT  (C),
        .PAYLOAD_BYTES (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .cmd_word (cmd_word),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_err = 0, t_valid = -1, t_err = -1;
    int base_v = 0, base_e = 0;
    logic [W-1:0] exp_word = '0, exp_pending = '0, prev_word = '0;
    logic [7:0]   pay [P];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor: exclusion, word only moves on cmd_valid, busy drops with the pulse.
    always @(negedge clk) begin
        if (reset) begin
            prev_word = '0;
        end else begin
            n_cmp++;
            if (cmd_valid && frame_err) begin
                n_bad++;
                $display("FAIL excl: cmd_valid=1 frame_err=1 at cycle %0d, want at most one", cyc);
            end
            if (cmd_valid) begin
                n_valid++;
                t_valid = cyc;
                check("commit_word", cmd_word, exp_pending);
                check("busy_at_valid", W'(busy), '0);
            end else begin
                check("hold_word", cmd_word, prev_word);
            end
            if (frame_err) begin
                n_err++;
                t_err = cyc;
            end
            prev_word = cmd_word;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int max_gap);
        int g;
        g = $urandom_range(0, max_gap);
        if (g > 0) wait_cyc(g);
    endtask

    // One 8N1 character; t returns the edge index just before the start bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t);
        t = cyc;
        uart_rx = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cyc(C);
        end
        uart_rx = stop;
        wait_cyc(C);
        uart_rx = 1'b1;
    endtask

    task automatic mark();
        base_v = n_valid;
        base_e = n_err;
    endtask

    task automatic expect_result(input string name, input int dv, input int de, input int tv, input int te);
        check({name, " valid_cnt"}, W'(n_valid - base_v), W'(dv));
        check({name, " err_cnt"},   W'(n_err - base_e),   W'(de));
        if (dv > 0) check({name, " valid_cycle"}, W'(t_valid), W'(tv));
        if (de > 0) check({name, " err_cycle"},   W'(t_err),   W'(te));
        check({name, " word"}, cmd_word, exp_word);
        check({name, " busy"}, W'(busy), '0);
    endtask

    // kind 0: good, 1: bad checksum, 2: zero stop bit on payload byte err_idx
    task automatic run_frame(input string name, input int kind, input int err_idx,
                             input int junk, input int max_gap, input bit resync);
        int           t, tb;
        logic [7:0]   cs, b;
        logic [W-1:0] pk;
        bit           stopped;
        cs = 8'd0;
        pk = '0;
        t  = 0;
        tb = 0;
        for (int i = 0; i < P; i++) begin
            cs = cs + pay[i];
            pk[W-1-8*i -: 8] = pay[i];
        end
        mark();
        exp_pending = (kind == 0) ? pk : exp_word;
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hAA) b = 8'h12;
            send_byte(b, 1'b1, t);
            idle(max_gap);
        end
        if (resync) begin
            send_byte(8'h12, 1'b1, t);
            send_byte(8'hAA, 1'b1, t);
        end
        send_byte(8'hAA, 1'b1, t);
        idle(max_gap);
        send_byte(8'h55, 1'b1, t);
        check({name, " busy_in_frame"}, W'(busy), W'(1));
        stopped = 1'b0;
        for (int i = 0; i < P; i++) begin
            if (!stopped) begin
                if (kind == 2 && i == err_idx) begin
                    send_byte(pay[i], 1'b0, tb);
                    wait_cyc(2 * C);
                    stopped = 1'b1;
                end else begin
                    send_byte(pay[i], 1'b1, t);
                    idle(max_gap);
                end
            end
        end
        if (!stopped) send_byte((kind == 1) ? cs - 8'd1 : cs, 1'b1, t);
        wait_cyc(3);
        if (kind == 0) exp_word = pk;
        case (kind)
            0:       expect_result(name, 1, 0, t + 3 + N, 0);
            1:       expect_result(name, 0, 1, 0, t + 3 + N);
            default: expect_result(name, 0, 1, 0, tb + 3 + N);
        endcase
    endtask

    task automatic rand_payload();
        for (int i = 0; i < P; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int         t_last;
        logic [7:0] sum;

        // reset values, then a long quiet line
        reset   = 1'b1;
        uart_rx = 1'b1;
        wait_cyc(5);
        check("rst word",  cmd_word,       '0);
        check("rst valid", W'(cmd_valid),  '0);
        check("rst err",   W'(frame_err),  '0);
        check("rst busy",  W'(busy),       '0);
        reset = 1'b0;
        wait_cyc(10000);
        check("idle word",  cmd_word,           '0);
        check("idle busy",  W'(busy),           '0);
        check("idle pulses", W'(n_valid + n_err), '0);

        // counting payload 01..1E
        sum = 8'd0;
        for (int i = 0; i < P; i++) begin
            pay[i] = 8'(i + 1);
            sum    = sum + pay[i];
        end
        check("model csum pin", W'(sum), W'(8'hD1));
        run_frame("good", 0, 0, 0, 0, 1'b0);
        check("good msb byte", W'(cmd_word[W-1 -: 8]), W'(8'h01));
        check("good lsb byte", W'(cmd_word[7:0]),      W'(8'h1E));

        run_frame("bad_csum", 1, 0, 0, 0, 1'b0);
        check("bad_csum keeps msb", W'(cmd_word[W-1 -: 8]), W'(8'h01));

        rand_payload();
        run_frame("resync", 0, 0, 0, 5, 1'b1);

        // timeout after ten payload bytes
        rand_payload();
        mark();
        exp_pending = exp_word;
        send_byte(8'hAA, 1'b1, t_last);
        send_byte(8'h55, 1'b1, t_last);
        for (int i = 0; i < 10; i++) send_byte(pay[i], 1'b1, t_last);
        check("timeout busy_before", W'(busy), W'(1));
        wait_cyc(T + 10);
        expect_result("timeout", 0, 1, 0, t_last + 4 + N + T);
        rand_payload();
        run_frame("after_timeout", 0, 0, 0, 3, 1'b0);

        rand_payload();
        run_frame("stop_err", 2, 5, 0, 0, 1'b0);
        rand_payload();
        run_frame("after_stop_err", 0, 0, 1, 3, 1'b0);

        // reset in the middle of payload byte 20
        rand_payload();
        send_byte(8'hAA, 1'b1, t_last);
        send_byte(8'h55, 1'b1, t_last);
        for (int i = 0; i < 20; i++) send_byte(pay[i], 1'b1, t_last);
        uart_rx = 1'b0;
        wait_cyc(3 * C);
        reset   = 1'b1;
        uart_rx = 1'b1;
        wait_cyc(1);
        check("midrst word",  cmd_word,      '0);
        check("midrst valid", W'(cmd_valid), '0);
        check("midrst err",   W'(frame_err), '0);
        check("midrst busy",  W'(busy),      '0);
        wait_cyc(4);
        reset    = 1'b0;
        exp_word = '0;
        wait_cyc(5);
        check("after_rst word", cmd_word, '0);
        rand_payload();
        run_frame("after_reset", 0, 0, 0, 2, 1'b0);

        // randomized frames
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            run_frame($sformatf("rand%0d", k), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, P - 1)), int'($urandom_range(0, 2)), 20, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
